imem_boot_loader: RTL and testbench

//   Hardware program loader for the single-cycle MIPS core.

---
 rtl/imem_boot_loader_pkg.sv | 29 ++
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader_byte_packer.sv | 37 +++
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 tb/tb_imem_boot_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared state encoding, stream framing constants and small helpers for the
// instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_WORD,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;

    typedef logic [8*LEN_BYTES-1:0] len_t;

    function automatic len_t len_join(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    // True when the requested word count does not fit in a 2**aw word memory.
    function automatic logic len_exceeds(input len_t n, input int aw);
        return 32'(n) > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
// master = loader side, slave = host stream source / IM write port side.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]                        in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              im_we;
    logic [ADDR_WIDTH-1:0]             im_addr;
    logic [imem_boot_loader_pkg::WORD_W-1:0] im_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte packer: holds the first WORD_BYTES-1 bytes of a word; 'word' and
// 'full' describe the word as completed by the byte being shifted in this cycle.
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);
    localparam int CNT_W = $clog2(WORD_BYTES);
    localparam int HOLD_W = 8 * (WORD_BYTES - 1);

    logic [HOLD_W-1:0] hold;
    logic [CNT_W-1:0]  cnt;

    assign word = {hold, byte_in};
    assign full = shift && (cnt == CNT_W'(WORD_BYTES - 1));

    // Counter wraps on the completing byte so the next word starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
            cnt  <= '0;
        end else if (clear) begin
            hold <= '0;
            cnt  <= '0;
        end else if (shift) begin
            hold <= word[HOLD_W-1:0];
            cnt  <= full ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// MIPS core in reset until a complete image has been written.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.master  bus,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t                 state;
    logic [7:0]             len_hi;
    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [ADDR_WIDTH-1:0]  last_idx;
    logic                   in_ready_q;
    logic                   im_we_q;
    logic [ADDR_WIDTH-1:0]  im_addr_q;
    logic [WORD_W-1:0]      im_wdata_q;

    logic                   xfer;
    len_t                   len;
    logic                   pk_clear;
    logic                   pk_shift;
    logic [WORD_W-1:0]      pk_word;
    logic                   pk_full;

    assign xfer     = bus.in_valid && in_ready_q;
    assign len      = len_join(len_hi, bus.in_data);
    assign pk_clear = (state == ST_IDLE) || (state == ST_LEN_LO);
    assign pk_shift = xfer && (state == ST_WORD);

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;

    imem_boot_loader_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .shift   (pk_shift),
        .byte_in (bus.in_data),
        .word    (pk_word),
        .full    (pk_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            len_hi     <= '0;
            word_idx   <= '0;
            last_idx   <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LEN_HI;
                        err        <= 1'b0;
                        cpu_rst    <= 1'b1;
                        busy       <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= bus.in_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        if (len == '0) begin
                            state      <= ST_DONE;
                            in_ready_q <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b0;
                        end else if (len_exceeds(len, ADDR_WIDTH)) begin
                            // Oversized image: refuse it and keep the core parked.
                            state      <= ST_IDLE;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state    <= ST_WORD;
                            word_idx <= '0;
                            last_idx <= ADDR_WIDTH'(32'(len) - 32'd1);
                        end
                    end
                end
                ST_WORD: begin
                    if (pk_full) begin
                        state      <= ST_WRITE;
                        in_ready_q <= 1'b0;
                        im_we_q    <= 1'b1;
                        im_addr_q  <= word_idx;
                        im_wdata_q <= pk_word;
                    end
                end
                ST_WRITE: begin
                    if (word_idx == last_idx) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        word_idx   <= word_idx + 1'b1;
                        state      <= ST_WORD;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the IM boot loader: reset, basic and gapped loads, edge
// lengths, start-while-busy, error clearing and abort by reset.
module tb_imem_boot_loader;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cpu_rst, busy, done, err;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int ready_viol = 0;

    logic [7:0] basic[$] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
                             8'h24, 8'h02, 8'h00, 8'h07};

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && bus.im_we) begin
            wr_addr.push_back(bus.im_addr);
            wr_data.push_back(bus.im_wdata);
            if (bus.in_ready) ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[i]) send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_basic_writes(input string tag);
        check({tag, "_count"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check({tag, "_addr0"}, 32'(wr_addr[0]), 32'd0);
            check({tag, "_data0"}, wr_data[0], 32'h2401_0005);
            check({tag, "_addr1"}, 32'(wr_addr[1]), 32'd1);
            check({tag, "_data1"}, wr_data[1], 32'h2402_0007);
        end
    endtask

    initial begin
        int lat;
        int changed;
        int bad;
        logic [31:0] w;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_im_we", bus.im_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_im_addr", 32'(bus.im_addr), 0);
        check("rst_im_wdata", bus.im_wdata, 0);
        rst = 1'b1;
        changed = 0;
        repeat (20) begin
            @(negedge clk);
            if ({cpu_rst, busy, done, err, bus.in_ready, bus.im_we} != 6'b100000 ||
                bus.im_addr != '0 || bus.im_wdata != '0) changed++;
        end
        check("idle_stable", changed, 0);

        // Basic load with write-latency probe after the 4th data byte
        clear_writes();
        pulse_start();
        check("start_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            send_byte(basic[i], 0);
            if (i == 5) begin
                @(negedge clk);
                check("we_latency", bus.im_we, 1);
                check("write_not_ready", bus.in_ready, 0);
                check("cpu_rst_held", cpu_rst, 1);
            end
        end
        wait_done(20, lat);
        check("basic_done_lat", lat, 2);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("basic_cpu_rst", cpu_rst, 0);
        check("basic_busy", busy, 0);
        check("hold_addr", 32'(bus.im_addr), 1);
        check("hold_wdata", bus.im_wdata, 32'h2402_0007);
        check_basic_writes("basic");

        // Same stream with random valid gaps
        clear_writes();
        pulse_start();
        send_stream(basic, 3);
        wait_done(20, lat);
        check("gap_done", lat > 0, 1);
        check_basic_writes("gap");
        check("ready_in_write", ready_viol, 0);

        // N == 0
        clear_writes();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done(5, lat);
        check("n0_done", (lat >= 1) && (lat <= 2), 1);
        check("n0_writes", wr_addr.size(), 0);
        @(negedge clk);
        check("n0_cpu_rst", cpu_rst, 0);

        // N == capacity
        clear_writes();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'hA500_0000 | 32'(i * 3);
            send_byte(w[31:24], 0);
            send_byte(w[23:16], 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        wait_done(20, lat);
        check("full_done", lat > 0, 1);
        check("full_count", wr_addr.size(), 1024);
        bad = 0;
        foreach (wr_addr[i]) begin
            if (wr_addr[i] != AW'(i) || wr_data[i] != (32'hA500_0000 | 32'(i * 3))) bad++;
        end
        check("full_bad", bad, 0);
        if (wr_addr.size() > 0) check("full_last_addr", 32'(wr_addr[$]), 32'h3FF);

        // N == capacity + 1
        clear_writes();
        pulse_start();
        check("restart_cpu_rst", cpu_rst, 1);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check("over_err", err, 1);
        check("over_cpu_rst", cpu_rst, 1);
        check("over_busy", busy, 0);
        check("over_ready", bus.in_ready, 0);
        wait_done(5, lat);
        check("over_no_done", lat, -1);
        check("over_writes", wr_addr.size(), 0);

        // start clears err; start while busy ignored
        clear_writes();
        pulse_start();
        check("start_clears_err", err, 0);
        check("start_cpu_rst", cpu_rst, 1);
        for (int i = 0; i < 4; i++) send_byte(basic[i], 0);
        pulse_start();
        for (int i = 4; i < 10; i++) send_byte(basic[i], 0);
        wait_done(20, lat);
        check("busy_start_done", lat > 0, 1);
        check_basic_writes("busy_start");

        // Abort by reset in the middle of word 1
        clear_writes();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(basic[i], 0);
        #2 rst = 1'b0;
        #1;
        check("abort_cpu_rst", cpu_rst, 1);
        check("abort_ready", bus.in_ready, 0);
        check("abort_we", bus.im_we, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_addr", 32'(bus.im_addr), 0);
        check("abort_wdata", bus.im_wdata, 0);
        check("abort_writes", wr_addr.size(), 1);
        @(negedge clk);
        rst = 1'b1;
        clear_writes();
        pulse_start();
        send_stream(basic, 1);
        wait_done(20, lat);
        check("reload_done", lat > 0, 1);
        check_basic_writes("reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
